r5p_soc_uart_ctl: RTL

//  Register-mapped controller sequencing the UART core's Avalon port. Buffers TX bytes and RX bytes
//  in FIFOs and moves them to/from the core without CPU polling. Sits between the SoC peripheral
//  bus and the UART core; raises one level interrupt to the CPU.

---
 rtl/r5p_soc_uart_pkg.sv | 45 ++++
 rtl/r5p_soc_fifo.sv | 55 +++++
 rtl/r5p_soc_uart_ctl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/r5p_soc_uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | r5p_soc_uart_pkg                                                            |
// | Register map, bit indices and shared types for the UART sequencing block.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package r5p_soc_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RXCNT  = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_PRT_ERR  = 6;
    localparam int ST_BUSY     = 7;

    localparam int CT_TX_EN = 0;
    localparam int CT_RX_EN = 1;
    localparam int CT_RXIE  = 2;
    localparam int CT_TXIE  = 3;
    localparam int CT_ERIE  = 4;

    typedef struct packed {
        logic erie;
        logic txie;
        logic rxie;
        logic rx_en;
        logic tx_en;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        GAP  = 2'd2,
        WR   = 2'd3
    } fsm_t;

endpackage
`default_nettype wire

// File: rtl/r5p_soc_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | r5p_soc_fifo                                                                |
// | Synchronous FIFO, pointers carry one extra wrap bit for full/empty.         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module r5p_soc_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wdt,
    input  logic                     pop,
    output logic [DW-1:0]            rdt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [AW:0] C_ONE = 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from the pre-edge pointers, so a push into a full FIFO is dropped
    // even when a pop happens in the same cycle.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + C_ONE;
            if (w_pop)  r_rp <= r_rp + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= wdt;
    end

    assign rdt   = r_mem[r_rp[AW-1:0]];
    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign level = r_wp - r_rp;

endmodule
`default_nettype wire

// File: rtl/r5p_soc_uart_ctl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | r5p_soc_uart_ctl                                                            |
// | Bus-mapped TX/RX FIFOs that sequence the UART core's Avalon port.           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module r5p_soc_uart_ctl
    import r5p_soc_uart_pkg::*;
#(
    parameter int   TXD    = 16,
    parameter int   RXD    = 16,
    parameter logic PRT_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_vld,
    input  logic        bus_wen,
    input  logic [3:0]  bus_adr,
    input  logic [31:0] bus_wdt,
    output logic [31:0] bus_rdt,
    output logic        bus_rdy,
    output logic        irq,
    output logic        uart_read,
    output logic        uart_write,
    output logic [31:0] uart_wdt,
    input  logic [31:0] uart_rdt,
    input  logic        uart_wait,
    input  logic        uart_int
);
    localparam int TAW = $clog2(TXD);
    localparam int RAW = $clog2(RXD);

    fsm_t        r_state;
    fsm_t        w_state_nxt;
    ctrl_t       r_ctrl;
    logic [7:0]  r_wdt;
    logic [31:0] r_rdt;
    logic        r_irq;
    logic        r_rx_ovf;
    logic        r_tx_ovf;
    logic        r_prt_err;

    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_sel;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_wdt_load;
    logic [7:0]  w_tx_head;
    logic [7:0]  w_rx_head;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [TAW:0] w_tx_level;
    logic [RAW:0] w_rx_level;
    logic [7:0]  w_status;
    logic [31:0] w_rdt;
    logic [2:0]  w_w1c;
    logic        w_set_rx_ovf;
    logic        w_set_tx_ovf;
    logic        w_set_prt;
    logic        w_unused;

    assign w_wr  = bus_vld & bus_wen;
    assign w_rd  = bus_vld & ~bus_wen;
    assign w_sel = bus_adr[3:2];

    assign w_tx_push = w_wr && (w_sel == REG_DATA);
    assign w_rx_pop  = w_rd && (w_sel == REG_DATA);

    r5p_soc_fifo #(.DW(8), .DEPTH(TXD)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .wdt   (bus_wdt[7:0]),
        .pop   (w_tx_pop),
        .rdt   (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (w_tx_level)
    );

    r5p_soc_fifo #(.DW(8), .DEPTH(RXD)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .wdt   (uart_rdt[7:0]),
        .pop   (w_rx_pop),
        .rdt   (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (w_rx_level)
    );

    // Read is tested first so a pending RX byte never waits behind a stalled TX stream;
    // WR never leaves before the core accepts, so read and write strobes cannot overlap.
    always_comb begin
        w_state_nxt = r_state;
        w_rx_push   = 1'b0;
        w_tx_pop    = 1'b0;
        w_wdt_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ctrl.rx_en && uart_int && !w_rx_full) begin
                    w_state_nxt = RD;
                end else if (r_ctrl.tx_en && !w_tx_empty) begin
                    w_state_nxt = WR;
                    w_wdt_load  = 1'b1;
                end
            end
            RD: begin
                w_rx_push   = uart_rdt[31];
                w_state_nxt = GAP;
            end
            GAP: w_state_nxt = IDLE;
            WR: begin
                if (!uart_wait) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    assign w_status = {(r_state != IDLE) | ~w_tx_empty, r_prt_err, r_tx_ovf, r_rx_ovf,
                       w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

    always_comb begin
        w_rdt = '0;
        case (w_sel)
            REG_DATA:   if (!w_rx_empty) w_rdt = {1'b1, 23'd0, w_rx_head};
            REG_STATUS: w_rdt[7:0] = w_status;
            REG_CTRL:   w_rdt[4:0] = r_ctrl;
            default:    w_rdt[RAW:0] = w_rx_level;
        endcase
    end

    assign w_w1c        = (w_wr && (w_sel == REG_STATUS)) ? bus_wdt[ST_PRT_ERR:ST_RX_OVF] : 3'b000;
    assign w_set_rx_ovf = (r_state == RD) & uart_rdt[30];
    assign w_set_prt    = (r_state == RD) & PRT_EN & uart_rdt[29];
    assign w_set_tx_ovf = w_tx_push & w_tx_full;

    // Clear is applied before set so a flag raised in the clearing cycle survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl    <= '0;
            r_wdt     <= '0;
            r_rdt     <= '0;
            r_irq     <= 1'b0;
            r_rx_ovf  <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_prt_err <= 1'b0;
        end else begin
            if (w_wr && (w_sel == REG_CTRL)) r_ctrl <= ctrl_t'(bus_wdt[4:0]);
            if (w_wdt_load) r_wdt <= w_tx_head;
            if (w_rd)       r_rdt <= w_rdt;
            r_rx_ovf  <= (r_rx_ovf  & ~w_w1c[0]) | w_set_rx_ovf;
            r_tx_ovf  <= (r_tx_ovf  & ~w_w1c[1]) | w_set_tx_ovf;
            r_prt_err <= (r_prt_err & ~w_w1c[2]) | w_set_prt;
            r_irq     <= (r_ctrl.rxie & ~w_rx_empty)
                       | (r_ctrl.txie & w_tx_empty & (r_state == IDLE))
                       | (r_ctrl.erie & (r_rx_ovf | r_tx_ovf | r_prt_err));
        end
    end

    assign bus_rdt    = r_rdt;
    assign bus_rdy    = 1'b1;
    assign irq        = r_irq;
    assign uart_read  = (r_state == RD);
    assign uart_write = (r_state == WR);
    assign uart_wdt   = {24'd0, r_wdt};

    assign w_unused = ^{bus_adr[1:0], bus_wdt[31:8], uart_rdt[28:8], w_tx_level};

endmodule
`default_nettype wire
